// File: rtl/risc_v_bus_pkg.sv
// Shared bus definitions for the open_risc_v memory interface.
package risc_v_bus_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;

  // Owner of the access whose read data returns this cycle.
  localparam logic [1:0] RSP_NONE = 2'd0;
  localparam logic [1:0] RSP_IF   = 2'd1;
  localparam logic [1:0] RSP_LS   = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory between the fetch (IF) and load/store (LS)
// ports. LS normally wins a collision, but a bounded run of LS grants while
// IF waits hands the next slot to IF. Read data has a fixed 1-cycle latency
// and is steered back to whichever port owned the access.
module mem_bus_arbiter
  import risc_v_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = BUS_ADDR_W,
  parameter int unsigned DATA_W     = BUS_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [DATA_W/8-1:0] ls_be_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned CNT_RAW  = $clog2(STARVE_MAX + 1);
  localparam int unsigned CNT_W    = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic             w_if_gnt;
  logic             w_ls_gnt;
  logic [1:0]       r_rsp;
  logic             r_wr;
  logic [CNT_W-1:0] r_starve_cnt;

  // Per-cycle grant: LS first unless IF has waited through STARVE_MAX LS grants.
  // Gated by rst so every output reads 0 while reset is held.
  always_comb begin
    w_if_gnt = 1'b0;
    w_ls_gnt = 1'b0;
    if (!rst) begin
      if (if_req_i && (!ls_req_i || (r_starve_cnt == STARVE_LIM))) begin
        w_if_gnt = 1'b1;
      end else if (ls_req_i) begin
        w_ls_gnt = 1'b1;
      end
    end
  end

  // Drive the memory port from the granted requester; idle fields are zero.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_if_gnt) begin
      mem_req_o  = 1'b1;
      mem_be_o   = '1;
      mem_addr_o = if_addr_i;
    end else if (w_ls_gnt) begin
      mem_req_o   = 1'b1;
      mem_we_o    = ls_we_i;
      mem_be_o    = ls_be_i;
      mem_addr_o  = ls_addr_i;
      mem_wdata_o = ls_wdata_i;
    end
  end

  // Remember who owns the access in flight so its data can be routed back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp <= RSP_NONE;
      r_wr  <= 1'b0;
    end else begin
      if (w_if_gnt) begin
        r_rsp <= RSP_IF;
      end else if (w_ls_gnt) begin
        r_rsp <= RSP_LS;
      end else begin
        r_rsp <= RSP_NONE;
      end
      r_wr <= w_ls_gnt & ls_we_i;
    end
  end

  // Count consecutive LS grants taken while IF is waiting, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!if_req_i || w_if_gnt) begin
      r_starve_cnt <= '0;
    end else if (w_ls_gnt && (r_starve_cnt != STARVE_LIM)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign if_gnt_o    = w_if_gnt;
  assign ls_gnt_o    = w_ls_gnt;
  assign if_rvalid_o = (r_rsp == RSP_IF);
  assign ls_rvalid_o = (r_rsp == RSP_LS);
  assign if_rdata_o  = (r_rsp == RSP_IF) ? mem_rdata_i : '0;
  // Store acks return zero rather than whatever the memory leaves on its bus.
  assign ls_rdata_o  = ((r_rsp == RSP_LS) && !r_wr) ? mem_rdata_i : '0;

  logic [BE_W-1:0] w_unused_be_w;
  assign w_unused_be_w = '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a behavioural memory answers the
// DUT, a reference arbiter predicts grants, and expected responses are
// queued at grant time and compared when rvalid is due.
module tb_mem_bus_arbiter;
  import risc_v_bus_pkg::*;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = DW / 8;
  localparam int unsigned SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o, if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          ls_req_i, ls_we_i;
  logic [BW-1:0] ls_be_i;
  logic [AW-1:0] ls_addr_i;
  logic [DW-1:0] ls_wdata_i;
  logic          ls_gnt_o, ls_rvalid_o;
  logic [DW-1:0] ls_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [BW-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // Behavioural single-port memory with 1-cycle read latency.
  logic [DW-1:0] mem     [0:1023];
  logic [DW-1:0] ref_mem [0:1023];

  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < int'(BW); b++)
          if (mem_be_o[b]) mem[mem_addr_o[11:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        mem_rdata_i <= 32'hBAD0_BAD0;
      end else begin
        mem_rdata_i <= mem[mem_addr_o[11:2]];
      end
    end
  end

  typedef struct {
    logic [1:0]    kind;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned m_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_rsp();
    rsp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
    end else begin
      e.kind = RSP_NONE;
      e.data = '0;
    end
    check_val("if_rvalid", 32'(if_rvalid_o), 32'(e.kind == RSP_IF));
    check_val("ls_rvalid", 32'(ls_rvalid_o), 32'(e.kind == RSP_LS));
    check_val("if_rdata", if_rdata_o, (e.kind == RSP_IF) ? e.data : 32'h0);
    check_val("ls_rdata", ls_rdata_o, (e.kind == RSP_LS) ? e.data : 32'h0);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_gnts"}, {30'h0, if_gnt_o, ls_gnt_o}, 32'h0);
    check_val({tag, "_rvalids"}, {30'h0, if_rvalid_o, ls_rvalid_o}, 32'h0);
    check_val({tag, "_rdata"}, if_rdata_o | ls_rdata_o, 32'h0);
    check_val({tag, "_memctl"}, {26'h0, mem_req_o, mem_we_o, mem_be_o}, 32'h0);
    check_val({tag, "_memaddr"}, mem_addr_o, 32'h0);
    check_val({tag, "_memwdata"}, mem_wdata_o, 32'h0);
  endtask

  // One bus cycle: check the response due now, drive requests, check the grant.
  task automatic step(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                      input logic [3:0] lb, input logic [31:0] la, input logic [31:0] lwd);
    logic ei, el;
    rsp_t e;
    @(negedge clk);
    check_rsp();
    if_req_i = ir; if_addr_i = ia;
    ls_req_i = lr; ls_we_i = lw; ls_be_i = lb; ls_addr_i = la; ls_wdata_i = lwd;
    #1;
    ei = ir && (!lr || (m_cnt == SMAX));
    el = lr && !ei;
    check_val("if_gnt", 32'(if_gnt_o), 32'(ei));
    check_val("ls_gnt", 32'(ls_gnt_o), 32'(el));
    check_val("mem_req", 32'(mem_req_o), 32'(ei || el));
    check_val("mem_we", 32'(mem_we_o), 32'(el && lw));
    check_val("mem_be", 32'(mem_be_o), ei ? 32'hF : (el ? 32'(lb) : 32'h0));
    check_val("mem_addr", mem_addr_o, ei ? ia : (el ? la : 32'h0));
    check_val("mem_wdata", mem_wdata_o, (el && lw) ? lwd : 32'h0);
    if (ei) begin
      e.kind = RSP_IF; e.data = ref_mem[ia[11:2]];
      sb.push_back(e);
    end else if (el) begin
      e.kind = RSP_LS; e.data = lw ? 32'h0 : ref_mem[la[11:2]];
      sb.push_back(e);
      if (lw)
        for (int b = 0; b < 4; b++)
          if (lb[b]) ref_mem[la[11:2]][8*b +: 8] = lwd[8*b +: 8];
    end
    if (!ir || ei) m_cnt = 0;
    else if (el && m_cnt != SMAX) m_cnt++;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic both(input logic [31:0] ia, input logic [31:0] la);
    step(1'b1, ia, 1'b1, 1'b0, 4'h0, la, 32'h0);
  endtask

  // Assert reset before the coming edge with requests still applied.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    @(negedge clk);
    check_zero(tag);
    sb.delete();
    m_cnt = 0;
    if_req_i = 1'b0; ls_req_i = 1'b0; ls_we_i = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = {16'hC0DE, 16'(i)};
      ref_mem[i] = {16'hC0DE, 16'(i)};
    end
    mem[32'h100 >> 2]     = 32'hDEAD_BEEF;
    ref_mem[32'h100 >> 2] = 32'hDEAD_BEEF;

    rst = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h4;
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_be_i = 4'hF; ls_addr_i = 32'h8; ls_wdata_i = 32'h55;
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    if_req_i = 1'b0; ls_req_i = 1'b0; ls_we_i = 1'b0;
    rst = 1'b0;

    // IF-only back-to-back fetches
    step(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle();

    // Collision: LS load wins, IF follows
    both(32'h10, 32'h100);
    step(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle();

    // Starvation: both held continuously
    for (int i = 0; i < 15; i++) both(32'h20, 32'h104 + 32'(4 * (i % 4)));
    idle();

    // IF withdraws before being granted
    both(32'h30, 32'h108);
    step(1'b0, 32'h30, 1'b1, 1'b0, 4'h0, 32'h10C, 32'h0);
    idle();

    // Partial store, then read it back
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h200, 32'h1234_5678);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0);
    step(1'b1, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle();

    // Reset with an IF read in flight
    step(1'b1, 32'h44, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    do_reset("rst_if");
    step(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle();

    // Reset with the starvation count part-way up
    for (int i = 0; i < 3; i++) both(32'h50, 32'h110);
    do_reset("rst_cnt");
    for (int i = 0; i < 6; i++) both(32'h54, 32'h114);
    idle();

    // Idle
    for (int i = 0; i < 10; i++) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
